// File: rtl/vga_spi_pkg.sv
// Definitions shared by both ends of the bar-graph SPI link.
// Covers the packet layout, the default bar count and the FSM state types.
package vga_spi_pkg;

  localparam int unsigned PKT_BITS   = 16;
  localparam int unsigned DEF_N_BARS = 15;

  // Sent LSB first, so the address goes out before the data.
  typedef struct packed {
    logic [7:0] data;
    logic [7:0] addr;
  } bar_pkt_t;

  typedef enum logic [1:0] {
    TxIdle,
    TxShift,
    TxTail
  } tx_state_e;

  typedef enum logic [1:0] {
    BarIdle,
    BarLoad,
    BarSend,
    BarGap
  } bar_state_e;

endpackage

// File: rtl/spi_shift_tx.sv
// LSB-first 16-bit serializer: frames a packet with CSEL and generates SCK.
// done_o is high in the last TAIL cycle, which is the cycle before CSEL drops.
module spi_shift_tx
  import vga_spi_pkg::*;
#(
  parameter int unsigned HALF_CYC = 25
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [PKT_BITS-1:0] pkt_i,
  output logic                done_o,
  output logic                sck_o,
  output logic                csel_o,
  output logic                mosi_o
);

  localparam int unsigned HW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam logic [HW-1:0] HALF_MAX = HW'(HALF_CYC - 1);

  tx_state_e           state_q, state_d;
  logic [HW-1:0]       half_q, half_d;
  logic [3:0]          bit_q, bit_d;
  logic [PKT_BITS-1:0] sreg_q, sreg_d;
  logic                sck_q, sck_d;
  logic                csel_q, csel_d;
  logic                mosi_q, mosi_d;
  logic                half_end;

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    sck_d    = sck_q;
    csel_d   = csel_q;
    mosi_d   = mosi_q;
    done_o   = 1'b0;
    half_end = (half_q == HALF_MAX);
    unique case (state_q)
      TxIdle: begin
        if (load_i) begin
          state_d = TxShift;
          sreg_d  = pkt_i;
          mosi_d  = pkt_i[0];
          csel_d  = 1'b1;
          sck_d   = 1'b0;
          half_d  = '0;
          bit_d   = '0;
        end
      end
      TxShift: begin
        half_d = half_end ? '0 : half_q + 1'b1;
        if (half_end) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling edge: advance to the next bit, or finish after bit 15.
            sck_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = TxTail;
            end else begin
              bit_d  = bit_q + 1'b1;
              sreg_d = sreg_q >> 1;
              mosi_d = sreg_q[1];
            end
          end
        end
      end
      TxTail: begin
        half_d = half_end ? '0 : half_q + 1'b1;
        if (half_end) begin
          state_d = TxIdle;
          csel_d  = 1'b0;
          mosi_d  = 1'b0;
          done_o  = 1'b1;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TxIdle;
      half_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      sck_q   <= 1'b0;
      csel_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      sck_q   <= sck_d;
      csel_q  <= csel_d;
      mosi_q  <= mosi_d;
    end
  end

  assign sck_o  = sck_q;
  assign csel_o = csel_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/bar_spi_sender.sv
// Bar-graph link transmitter: shadows N_BARS heights and sends each changed bar
// to the display as a 16-bit SPI packet, scheduled round-robin.
module bar_spi_sender
  import vga_spi_pkg::*;
#(
  parameter int unsigned N_BARS   = DEF_N_BARS,
  parameter int unsigned HALF_CYC = 25,
  parameter int unsigned GAP_CYC  = 50
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       bar_we,
  input  logic [7:0] bar_addr,
  input  logic [7:0] bar_data,
  output logic       spi_sck,
  output logic       spi_csel,
  output logic       spi_mosi,
  output logic       busy,
  output logic       pkt_done
);

  localparam int unsigned IW = (N_BARS > 1) ? $clog2(N_BARS) : 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC - 1);

  bar_state_e                state_q, state_d;
  logic [N_BARS-1:0][7:0]    shadow_q, shadow_d;
  logic [N_BARS-1:0]         dirty_q, dirty_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic                      busy_q, busy_d;
  logic                      pkt_done_q, pkt_done_d;

  logic          wr_hit;
  logic [IW-1:0] wr_idx;
  logic          found;
  logic [IW-1:0] sel_idx;
  logic          tx_load;
  logic          tx_done;
  bar_pkt_t      tx_pkt;

  assign wr_hit = bar_we && (32'(bar_addr) < N_BARS);
  assign wr_idx = bar_addr[IW-1:0];

  // First dirty bar at or after rr_ptr, wrapping at N_BARS.
  always_comb begin
    int unsigned j;
    j       = 0;
    found   = 1'b0;
    sel_idx = rr_ptr_q;
    for (int unsigned i = 0; i < N_BARS; i++) begin
      j = 32'(rr_ptr_q) + i;
      if (j >= N_BARS) j = j - N_BARS;
      if (!found && dirty_q[IW'(j)]) begin
        found   = 1'b1;
        sel_idx = IW'(j);
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (wr_hit) shadow_d[wr_idx] = bar_data;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    gap_d       = gap_q;
    dirty_d     = dirty_q;
    pkt_done_d  = 1'b0;
    tx_load     = 1'b0;
    tx_pkt.data = shadow_q[idx_q];
    tx_pkt.addr = 8'(idx_q);
    unique case (state_q)
      BarIdle: begin
        if (found) begin
          state_d = BarLoad;
          idx_d   = sel_idx;
        end
      end
      BarLoad: begin
        tx_load        = 1'b1;
        dirty_d[idx_q] = 1'b0;
        rr_ptr_d       = (32'(idx_q) == N_BARS - 1) ? '0 : idx_q + 1'b1;
        state_d        = BarSend;
      end
      BarSend: begin
        if (tx_done) begin
          state_d    = BarGap;
          gap_d      = '0;
          pkt_done_d = 1'b1;
        end
      end
      BarGap: begin
        if (gap_q == GAP_MAX) state_d = BarIdle;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = BarIdle;
    endcase
    // A write landing in the LOAD cycle must survive the clear.
    if (wr_hit) dirty_d[wr_idx] = 1'b1;
    busy_d = (state_d != BarIdle);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BarIdle;
      shadow_q   <= '0;
      dirty_q    <= '1;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      dirty_q    <= dirty_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  spi_shift_tx #(
    .HALF_CYC(HALF_CYC)
  ) u_tx (
    .clk_i (CLOCK_50),
    .rst_ni(rst_n),
    .load_i(tx_load),
    .pkt_i (tx_pkt),
    .done_o(tx_done),
    .sck_o (spi_sck),
    .csel_o(spi_csel),
    .mosi_o(spi_mosi)
  );

  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_bar_spi_sender.sv
// Directed bench for bar_spi_sender with a behavioural display receiver that
// captures packets on SCK rises and commits them when CSEL drops.
module tb_bar_spi_sender;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       bar_we   = 1'b0;
  logic [7:0] bar_addr = 8'd0;
  logic [7:0] bar_data = 8'd0;
  logic       spi_sck, spi_csel, spi_mosi, busy, pkt_done;

  int total = 0;
  int bad   = 0;

  bar_spi_sender dut (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .bar_we  (bar_we),
    .bar_addr(bar_addr),
    .bar_data(bar_data),
    .spi_sck (spi_sck),
    .spi_csel(spi_csel),
    .spi_mosi(spi_mosi),
    .busy    (busy),
    .pkt_done(pkt_done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Receiver model and link monitors.
  logic [15:0] rx_sh = 16'd0;
  int          rx_cnt = 0;
  logic [7:0]  rx_mem [0:255];
  logic [15:0] pkt_q [$];
  int          rise_q [$];
  int          cyc = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          done_cnt = 0;

  always @(posedge spi_csel) begin
    rx_cnt = 0;
    rise_q.push_back(cyc);
  end

  always @(posedge spi_sck) begin
    if (spi_csel) begin
      rx_sh  = {spi_mosi, rx_sh[15:1]};
      rx_cnt = rx_cnt + 1;
    end
  end

  always @(negedge spi_csel) begin
    if (rx_cnt == 16) begin
      rx_mem[rx_sh[7:0]] = rx_sh[15:8];
      pkt_q.push_back(rx_sh);
    end
    rx_cnt = 0;
  end

  always @(posedge CLOCK_50) begin
    cyc = cyc + 1;
    if (pkt_done === 1'b1) done_cnt = done_cnt + 1;
    if (spi_csel === 1'b1) begin
      cur_len = cur_len + 1;
    end else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
  end

  task automatic wait_quiet(output bit ok);
    int q;
    int n;
    q = 0;
    n = 0;
    while (q < 8 && n < 25000) begin
      @(negedge CLOCK_50);
      n = n + 1;
      if (busy === 1'b0) q = q + 1;
      else q = 0;
    end
    ok = (q >= 8);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLOCK_50);
    bar_we   = 1'b1;
    bar_addr = a;
    bar_data = d;
    @(negedge CLOCK_50);
    bar_we = 1'b0;
  endtask

  task automatic test_reset;
    bit          ok;
    logic [15:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    total++;
    if ({spi_sck, spi_csel, spi_mosi, busy, pkt_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 00000",
               {spi_sck, spi_csel, spi_mosi, busy, pkt_done});
    end
    pkt_q.delete();
    rise_q.delete();
    done_cnt = 0;
    rst_n = 1'b1;
    wait_quiet(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL refresh_quiet: busy=%b required idle", busy);
    end
    total++;
    if (pkt_q.size() != 15) begin
      bad++;
      $display("FAIL refresh_count: got %0d packets required 15", pkt_q.size());
    end
    for (int i = 0; i < 15; i++) begin
      got = (pkt_q.size() > i) ? pkt_q[i] : 16'hxxxx;
      total++;
      if (got !== {8'h00, 8'(i)}) begin
        bad++;
        $display("FAIL refresh_pkt%0d: got %h required %h", i, got, {8'h00, 8'(i)});
      end
    end
    total++;
    if (done_cnt != 15) begin
      bad++;
      $display("FAIL refresh_done_pulses: got %0d required 15", done_cnt);
    end
    total++;
    if (rise_q.size() < 2 || (rise_q[1] - rise_q[0]) != 877) begin
      bad++;
      $display("FAIL packet_period: got %0d required 877",
               (rise_q.size() < 2) ? -1 : rise_q[1] - rise_q[0]);
    end
  endtask

  task automatic test_single;
    bit ok;
    logic [15:0] got;
    pkt_q.delete();
    @(negedge CLOCK_50);
    bar_we   = 1'b1;
    bar_addr = 8'd3;
    bar_data = 8'hA5;
    @(negedge CLOCK_50);
    bar_we = 1'b0;
    total++;
    if ({busy, spi_csel} !== 2'b00) begin
      bad++;
      $display("FAIL single_idle: got busy/csel %b required 00", {busy, spi_csel});
    end
    @(negedge CLOCK_50);
    total++;
    if ({busy, spi_csel} !== 2'b10) begin
      bad++;
      $display("FAIL single_load: got busy/csel %b required 10", {busy, spi_csel});
    end
    @(negedge CLOCK_50);
    total++;
    if ({spi_csel, spi_mosi, spi_sck} !== 3'b110) begin
      bad++;
      $display("FAIL single_first_bit: got csel/mosi/sck %b required 110",
               {spi_csel, spi_mosi, spi_sck});
    end
    wait_quiet(ok);
    got = (pkt_q.size() == 1) ? pkt_q[0] : 16'hxxxx;
    total++;
    if (!ok || got !== 16'hA503) begin
      bad++;
      $display("FAIL single_bits: got %h (count %0d) required a503", got, pkt_q.size());
    end
    total++;
    if (last_len != 825) begin
      bad++;
      $display("FAIL single_csel_len: got %0d required 825", last_len);
    end
  endtask

  task automatic test_order;
    bit          ok;
    logic [15:0] got;
    logic [15:0] exp [3];
    exp[0] = 16'h7107;
    exp[1] = 16'h9309;
    exp[2] = 16'h2202;
    pkt_q.delete();
    @(negedge CLOCK_50);
    bar_we = 1'b1; bar_addr = 8'd7; bar_data = 8'h71;
    @(negedge CLOCK_50);
    bar_addr = 8'd2; bar_data = 8'h22;
    @(negedge CLOCK_50);
    bar_addr = 8'd9; bar_data = 8'h93;
    @(negedge CLOCK_50);
    bar_we = 1'b0;
    wait_quiet(ok);
    total++;
    if (!ok || pkt_q.size() != 3) begin
      bad++;
      $display("FAIL order_count: got %0d packets required 3", pkt_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (pkt_q.size() > i) ? pkt_q[i] : 16'hxxxx;
      total++;
      if (got !== exp[i]) begin
        bad++;
        $display("FAIL order_pkt%0d: got %h required %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_load_collision;
    bit          ok;
    logic [15:0] got;
    pkt_q.delete();
    @(negedge CLOCK_50);
    bar_we = 1'b1; bar_addr = 8'd5; bar_data = 8'h10;
    @(negedge CLOCK_50);
    bar_we = 1'b0;
    @(negedge CLOCK_50);
    total++;
    if ({busy, spi_csel} !== 2'b10) begin
      bad++;
      $display("FAIL collide_load: got busy/csel %b required 10", {busy, spi_csel});
    end
    bar_we = 1'b1; bar_addr = 8'd5; bar_data = 8'h20;
    @(negedge CLOCK_50);
    bar_we = 1'b0;
    wait_quiet(ok);
    got = (pkt_q.size() > 0) ? pkt_q[0] : 16'hxxxx;
    total++;
    if (!ok || got !== 16'h1005) begin
      bad++;
      $display("FAIL collide_first: got %h required 1005", got);
    end
    got = (pkt_q.size() == 2) ? pkt_q[1] : 16'hxxxx;
    total++;
    if (got !== 16'h2005) begin
      bad++;
      $display("FAIL collide_second: got %h (count %0d) required 2005", got, pkt_q.size());
    end
  endtask

  task automatic test_invalid;
    int busy_seen;
    pkt_q.delete();
    busy_seen = 0;
    wr(8'd15, 8'h77);
    wr(8'd200, 8'h88);
    repeat (60) begin
      @(negedge CLOCK_50);
      if (busy !== 1'b0) busy_seen++;
    end
    total++;
    if (busy_seen != 0 || pkt_q.size() != 0) begin
      bad++;
      $display("FAIL invalid_addr: got %0d busy cycles, %0d packets, required 0 and 0",
               busy_seen, pkt_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit          ok;
    int          n;
    logic [15:0] got;
    pkt_q.delete();
    wr(8'd1, 8'hFF);
    n = 0;
    while (rx_cnt != 8 && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    repeat (30) @(negedge CLOCK_50);
    total++;
    if (spi_csel !== 1'b1 || rx_cnt != 8) begin
      bad++;
      $display("FAIL mid_frame: got csel=%b bits=%0d required csel=1 bits=8", spi_csel, rx_cnt);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({spi_sck, spi_csel, spi_mosi, busy, pkt_done} !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b required 00000",
               {spi_sck, spi_csel, spi_mosi, busy, pkt_done});
    end
    repeat (2) @(negedge CLOCK_50);
    pkt_q.delete();
    done_cnt = 0;
    rst_n = 1'b1;
    wait_quiet(ok);
    total++;
    if (!ok || pkt_q.size() != 15 || done_cnt != 15) begin
      bad++;
      $display("FAIL mid_refresh_count: got %0d packets %0d pulses required 15 and 15",
               pkt_q.size(), done_cnt);
    end
    for (int i = 0; i < 15; i++) begin
      got = (pkt_q.size() > i) ? pkt_q[i] : 16'hxxxx;
      total++;
      if (got !== {8'h00, 8'(i)}) begin
        bad++;
        $display("FAIL mid_refresh_pkt%0d: got %h required %h", i, got, {8'h00, 8'(i)});
      end
    end
  endtask

  task automatic test_loopback;
    bit         ok;
    logic [7:0] ref_mem [15];
    logic [7:0] a;
    logic [7:0] d;
    for (int i = 0; i < 15; i++) ref_mem[i] = 8'h00;
    for (int k = 0; k < 10; k++) begin
      a = 8'($urandom_range(0, 14));
      d = 8'($urandom_range(0, 255));
      wr(a, d);
      ref_mem[a[3:0]] = d;
      repeat ($urandom_range(0, 1200)) @(negedge CLOCK_50);
    end
    wait_quiet(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL loopback_quiet: busy=%b required idle", busy);
    end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (rx_mem[i] !== ref_mem[i]) begin
        bad++;
        $display("FAIL loopback_bar%0d: got %h required %h", i, rx_mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_load_collision();
    test_invalid();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bar_spi_sender.md
# bar_spi_sender

Transmit side of the bar-graph display link: holds a local shadow of the N 8-bit bar heights and serializes changed bars to the VGA bar display over its SPI-style link (SCK, active-high CSEL, MOSI). The block sits in the producer design (e.g. the spectrum/level computation) and drives the GPIO pins the display samples. Each packet is 16 bits, sent LSB first: bits [7:0] are the bar index and bits [15:8] are the bar value. The display samples MOSI on SCK rising edges while CSEL=1 and commits the packet while CSEL=0.

## Interface
- N_BARS, 15, number of bars; valid indices are 0..N_BARS-1.
- HALF_CYC, 25, SCK half-period in CLOCK_50 cycles (1 MHz SCK).
- GAP_CYC, 50, CLOCK_50 cycles that CSEL is held low after each packet; minimum 4.
- CLOCK_50  in  1  system clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- bar_we  in  1  write strobe for the shadow register.
- bar_addr  in  8  bar index; writes with bar_addr ≥ N_BARS are ignored.
- bar_data  in  8  bar height.
- spi_sck  out  1  serial clock; idles low.
- spi_csel  out  1  active-high packet frame.
- spi_mosi  out  1  serial data.
- busy  out  1  high whenever the state is not IDLE.
- pkt_done  out  1  one-cycle pulse when a packet's CSEL frame ends.

## Operation
- Reset values: spi_sck=0, spi_csel=0, spi_mosi=0, busy=0, pkt_done=0, all shadow values=0, all dirty bits=1, rr_ptr=0, state=IDLE.
  - Because all dirty bits are set, the first action after reset is a full refresh of zeros. This overwrites any partial packet the display committed when reset hit mid-frame.
- Writes: a valid bar_we stores the value in shadow[addr] and sets dirty[addr] on the same edge.
  - Writes are always accepted, including while busy.
  - Rewriting a bar that is already dirty keeps only the last value.
- Scheduler: in IDLE, if any dirty bit is set, select the first dirty index found searching from rr_ptr upward, wrapping from N_BARS-1 to 0.
- States:
  - IDLE → LOAD when any bit is dirty.
  - LOAD (1 cycle): snapshot {shadow[idx], idx} into a 16-bit shift register, clear dirty[idx], set rr_ptr = idx+1 (wraps to 0 after N_BARS-1).
    - If bar_we targets idx in this same cycle, the set wins: dirty stays 1 and the new value is sent in a later packet.
  - SHIFT: 16 bit-slots. For each slot, SCK is low for HALF_CYC cycles with MOSI = current bit, then high for HALF_CYC cycles. The register shifts right when SCK falls.
  - TAIL: after the 16th high phase, SCK low and CSEL still 1 for HALF_CYC cycles.
  - GAP: CSEL=0 for GAP_CYC cycles, then → IDLE. pkt_done pulses in the first GAP cycle.
- MOSI is only meaningful while CSEL=1. Drive it to 0 in IDLE and GAP.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- bar_we sampled at edge k, with the block in IDLE and no other dirty bit set:
  - LOAD occurs in cycle k+1.
  - spi_csel=1 and spi_mosi=bit0 are visible after edge k+2.
- CSEL high duration: 33·HALF_CYC cycles (825 at default). Exactly 16 SCK rising edges fall inside it.
- The first SCK rise comes HALF_CYC cycles after CSEL rises. The last SCK fall comes HALF_CYC cycles before CSEL falls.
- Packet-to-packet period for back-to-back dirty bars: 33·HALF_CYC + GAP_CYC + 2 cycles (IDLE + LOAD) = 877 at default.
- Counters: half-period counter is ceil(log2(HALF_CYC)) bits; bit counter is 4 bits, terminal value 15; gap counter is sized to GAP_CYC.
- Reset asserted mid-packet: outputs drop to their reset values immediately (asynchronous). Sending resumes with a full refresh after rst_n deasserts.

## Structure
- Shared package vga_spi_pkg, also imported by the display side:
  - PKT_BITS=16.
  - typedef struct packed { logic [7:0] data; logic [7:0] addr; } bar_pkt_t.
  - Default N_BARS.
- One sub-module, spi_shift_tx: the 16-bit LSB-first serializer with SCK/CSEL generation.
  - Interface: load, pkt, done handshake.
  - The top level keeps the shadow registers, dirty bits, round-robin scheduler and GAP timer.

## Test plan
- Reset then idle: packets for indices 0..14, all with data 0x00, in ascending order; 15 pkt_done pulses, then busy=0.
- After the refresh, write bar 3 = 0xA5: MOSI sampled at the 16 SCK rises is 1,1,0,0,0,0,0,0,1,0,1,0,0,1,0,1; CSEL high for 825 cycles.
- Write bars 7, 2 and 9 in a single idle cycle sequence with rr_ptr=4: send order is 7, 9, 2.
- Write bar 5 = 0x10 in its LOAD cycle, then 0x20: the packet carries the older snapshot, and a second packet for bar 5 carries 0x20.
- Write bar_addr=15 or 200: no packet and busy stays 0. Assert rst_n low during bit 8: all outputs go to 0 at once, then a full 15-bar zero refresh follows.
- Loopback check: connect a behavioural model of the display receiver. After random writes settle, the model's registers equal the shadow values, sampled when busy=0.
